// File: rtl/instr_mem_fetch.sv
// Instruction memory with a valid/ready fetch port, programmable wait states,
// byte-organised storage with selectable byte order, fault flags for misaligned
// or out-of-range fetches, and a word-write load port for filling the program.
module instr_mem_fetch #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_STATES = 0,
  parameter bit BIG_ENDIAN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic [1:0]  rsp_fault,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int          AW        = (DEPTH_BYTES > 4) ? $clog2(DEPTH_BYTES) : 2;
  localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [31:0]     addr_q;
  logic [3:0]      count;
  logic [7:0]      mem [DEPTH_BYTES];

  logic            accept;
  logic            entering_resp;
  logic [31:0]     fetch_addr;
  logic [1:0]      fetch_fault;
  logic [AW-1:0]   rd_base;
  logic [7:0]      rd_byte [4];
  logic [31:0]     fetch_word;
  logic            load_ok;
  logic [AW-1:0]   wr_base;

  assign accept        = req_valid && req_ready;
  assign entering_resp = (state_next == S_RESP) && (state != S_RESP);

  // With zero wait states the read happens on the accept edge, so the live
  // request address is used; otherwise the latched address is used.
  assign fetch_addr  = (state == S_IDLE) ? req_addr : addr_q;
  assign fetch_fault = {fetch_addr > LAST_WORD, fetch_addr[1:0] != 2'b00};
  assign rd_base     = fetch_addr[AW-1:0] & ~AW'(3);

  // Loads are forced word-aligned and silently dropped beyond the last word.
  assign load_ok = load_we && (load_addr <= LAST_WORD);
  assign wr_base = load_addr[AW-1:0] & ~AW'(3);

  // State register: reset discards any in-flight fetch.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic for the IDLE -> WAIT -> RESP handshake.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
      S_WAIT:  if (count == 4'd1) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Handshake outputs; a load in IDLE takes priority over a fetch request.
  always_comb begin
    req_ready = (state == S_IDLE) && !load_we && !rst;
    rsp_valid = (state == S_RESP);
  end

  // Gather the four bytes of the addressed word in the configured order.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      rd_byte[k] = mem[rd_base | AW'(k)];
    end
    if (BIG_ENDIAN) fetch_word = {rd_byte[0], rd_byte[1], rd_byte[2], rd_byte[3]};
    else            fetch_word = {rd_byte[3], rd_byte[2], rd_byte[1], rd_byte[0]};
  end

  // Address latch, wait counter and response capture on the edge entering RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= 32'd0;
      count     <= 4'd0;
      rsp_instr <= 32'd0;
      rsp_fault <= 2'b00;
    end else begin
      if (accept) begin
        addr_q <= req_addr;
        count  <= WAIT_INIT;
      end else if (state == S_WAIT) begin
        count <= count - 4'd1;
      end
      if (entering_resp) begin
        rsp_fault <= fetch_fault;
        rsp_instr <= (fetch_fault != 2'b00) ? 32'd0 : fetch_word;
      end
    end
  end

  // Storage write; uncleared by reset, and a read on the same edge sees old data.
  always_ff @(posedge clk) begin
    if (load_ok) begin
      for (int k = 0; k < 4; k++) begin
        if (BIG_ENDIAN) mem[wr_base | AW'(k)] <= load_data[31-8*k -: 8];
        else            mem[wr_base | AW'(k)] <= load_data[8*k +: 8];
      end
    end
  end

endmodule
